// File: rtl/apb_reg_bank.sv
// APB slave register bank: NUM_REGS word registers with wait states, read-only mask and error responses.
// Optional byte-strobe support is compiled in when APB_PSTRB_EN is defined.
module apb_reg_bank #(
    parameter int unsigned                       ADDR_WIDTH   = 32,
    parameter int unsigned                       DATA_WIDTH   = 32,
    parameter int unsigned                       NUM_REGS     = 8,
    parameter logic [ADDR_WIDTH-1:0]             BASE_ADDR    = '0,
    parameter int unsigned                       WAIT_STATES  = 0,
    parameter int unsigned                       CTRL_WIDTH   = 4,
    parameter logic [NUM_REGS-1:0]               RO_MASK      = NUM_REGS'(2),
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]    RESET_VALUES = {32'h0, 32'h0, 32'h0, 32'h0000FFFF,
                                                                 32'hA5A50000, 32'h12349876,
                                                                 32'h5A5A5555, 32'h0},
    parameter logic [DATA_WIDTH-1:0]             ERR_DATA     = DATA_WIDTH'(32'hDEADDEAD)
) (
    input  logic                    pclk_i,
    input  logic                    preset_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
`ifdef APB_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
`endif
    output logic                    pready_o,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pslverr_o
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [DATA_WIDTH-1:0] CTRL_MASK  = DATA_WIDTH'((64'd1 << CTRL_WIDTH) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   armed_q, armed_d;
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0]  rst_vals [NUM_REGS];

    logic [ADDR_WIDTH-1:0]  addr_off;
    logic [ADDR_WIDTH-1:0]  word_off;
    logic [IDX_W-1:0]       idx;
    logic [DATA_WIDTH-1:0]  wmask;
    logic                   strb_err;
    logic                   acc_err;
    logic [DATA_WIDTH-1:0]  wr_val;
    logic [DATA_WIDTH-1:0]  rd_val;
    logic                   commit;

    // Reset image per register; register 0 only keeps its implemented control bits.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_rst
        if (g == 0) begin : g_ctrl
            assign rst_vals[g] = RESET_VALUES[g*DATA_WIDTH +: DATA_WIDTH] & CTRL_MASK;
        end else begin : g_word
            assign rst_vals[g] = RESET_VALUES[g*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Address decode, error classification and candidate read/write values.
    always_comb begin
        addr_off = paddr_i - BASE_ADDR;
        word_off = addr_off >> 2;
        idx      = IDX_W'(word_off);
        wmask    = '1;
        strb_err = 1'b0;
`ifdef APB_PSTRB_EN
        for (int k = 0; k < DATA_WIDTH/8; k++) begin
            wmask[k*8 +: 8] = {8{pstrb_i[k]}};
        end
        strb_err = !pwrite_i && (pstrb_i != '0);
`endif
        acc_err  = (paddr_i[1:0] != 2'b00)
                || (paddr_i < BASE_ADDR)
                || (word_off >= NUM_REGS_A)
                || (pwrite_i && RO_MASK[idx])
                || strb_err;
        wr_val   = (regs_q[idx] & ~wmask) | (pwdata_i & wmask);
        if (idx == '0) begin
            wr_val = wr_val & CTRL_MASK;
        end
        rd_val   = acc_err ? ERR_DATA : regs_q[idx];
    end

    // Transfer FSM; commit happens on the edge that enters RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        armed_d   = armed_q | ~penable_i;
        commit    = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
        regs_d    = regs_q;

        unique case (state_q)
            S_IDLE: begin
                if (psel_i && penable_i && armed_q) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!psel_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                // A penable still high here belongs to the finished transfer.
                state_d = S_IDLE;
                armed_d = ~penable_i;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit) begin
            pready_d  = 1'b1;
            pslverr_d = acc_err;
            if (!pwrite_i) begin
                prdata_d = rd_val;
            end else if (!acc_err) begin
                regs_d[idx] = wr_val;
            end
        end
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            armed_q   <= 1'b1;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            regs_q    <= rst_vals;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            regs_q    <= regs_d;
        end
    end

    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;
    assign prdata_o  = prdata_q;

endmodule
